// File: rtl/snoop_pkg.sv
// Shared definitions for the snooping bus controller: message codes placed
// on the bus, snooper response codes, MSI line states and the controller
// FSM encoding.
package snoop_pkg;

  // Width of a cache index on the bus and memory interfaces (up to 8 caches).
  localparam int SRC_W = 3;

  typedef enum logic [1:0] {
    MSG_NONE       = 2'd0,
    MSG_READ_MISS  = 2'd1,
    MSG_WRITE_MISS = 2'd2,
    MSG_INVALIDATE = 2'd3
  } msg_e;

  typedef enum logic [1:0] {
    SIG_NONE         = 2'd0,
    SIG_WRITEBACK    = 2'd1,
    SIG_ABORT        = 2'd2,
    SIG_WB_AND_ABORT = 2'd3
  } snoop_sig_e;

  typedef enum logic [1:0] {
    MSI_INVALID  = 2'd0,
    MSI_SHARED   = 2'd1,
    MSI_MODIFIED = 2'd2
  } msi_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_BROADCAST = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_FETCH     = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

endpackage

// File: rtl/snoop_bus_controller_if.sv
// Snoop bus signal bundle between the controller and the caches.
//   i_Req/i_Req_Msg/i_Req_Addr   : per-cache requests (packed per cache)
//   o_Grant                      : one-hot transaction owner
//   o_Bus_*                      : broadcast to all snoopers
//   i_Snoop_Ack/i_Snoop_Signal   : per-cache snoop responses
//   o_Mem_*/i_Mem_Done           : memory writeback/fetch handshake
//   o_Done/o_Error               : completion pulse and sticky protocol error
// modport master: controller side; modport slave: cache/memory side.
interface snoop_bus_controller_if
  import snoop_pkg::*;
#(
  parameter int N_CPU  = 4,
  parameter int ADDR_W = 8
);
  logic [N_CPU-1:0]        i_Req;
  logic [2*N_CPU-1:0]      i_Req_Msg;
  logic [ADDR_W*N_CPU-1:0] i_Req_Addr;
  logic [N_CPU-1:0]        o_Grant;
  logic                    o_Bus_Valid;
  logic [1:0]              o_Bus_Msg;
  logic [ADDR_W-1:0]       o_Bus_Addr;
  logic [SRC_W-1:0]        o_Bus_Src;
  logic [N_CPU-1:0]        i_Snoop_Ack;
  logic [2*N_CPU-1:0]      i_Snoop_Signal;
  logic                    o_Mem_Req;
  logic                    o_Mem_Wb;
  logic [SRC_W-1:0]        o_Mem_Src;
  logic                    i_Mem_Done;
  logic [N_CPU-1:0]        o_Done;
  logic                    o_Error;

  modport master (
    input  i_Req, i_Req_Msg, i_Req_Addr, i_Snoop_Ack, i_Snoop_Signal, i_Mem_Done,
    output o_Grant, o_Bus_Valid, o_Bus_Msg, o_Bus_Addr, o_Bus_Src,
           o_Mem_Req, o_Mem_Wb, o_Mem_Src, o_Done, o_Error
  );

  modport slave (
    output i_Req, i_Req_Msg, i_Req_Addr, i_Snoop_Ack, i_Snoop_Signal, i_Mem_Done,
    input  o_Grant, o_Bus_Valid, o_Bus_Msg, o_Bus_Addr, o_Bus_Src,
           o_Mem_Req, o_Mem_Wb, o_Mem_Src, o_Done, o_Error
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   req   : request vector
//   ptr   : index where the search starts
//   grant : one-hot winner, idx : winner index, any : some request present
module rr_arbiter
  import snoop_pkg::*;
#(
  parameter int N_CPU = 4
) (
  input  logic [N_CPU-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [N_CPU-1:0] grant,
  output logic [SRC_W-1:0] idx,
  output logic             any
);

  // Step k of the search visits cache (ptr + k) mod N_CPU; the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N_CPU; k++) begin
      for (int i = 0; i < N_CPU; i++) begin
        if (!any && req[i] && (i == (int'(ptr) + k) % N_CPU)) begin
          any      = 1'b1;
          grant[i] = 1'b1;
          idx      = SRC_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/snoop_bus_controller.sv
// Snooping bus controller: arbitrates cache requests round-robin, broadcasts
// the winner's message, collects snoop responses, sequences an optional
// dirty-line writeback (with retry on abort) and a memory fetch, then pulses
// o_Done to the owner.
//   i_Clk, i_Reset_n : clock, asynchronous active-low reset
//   bus              : snoop_bus_controller_if master modport
module snoop_bus_controller
  import snoop_pkg::*;
#(
  parameter int N_CPU  = 4,
  parameter int ADDR_W = 8
) (
  input logic                     i_Clk,
  input logic                     i_Reset_n,
  snoop_bus_controller_if.master  bus
);

  localparam logic [SRC_W-1:0] LAST = SRC_W'(N_CPU - 1);

  state_e            state_q, state_d;
  logic [SRC_W-1:0]  owner_q, ptr_q, wb_src_q;
  logic [N_CPU-1:0]  owner_oh_q;
  logic [1:0]        msg_q;
  logic [ADDR_W-1:0] addr_q;
  logic              abort_q, error_q;

  logic [N_CPU-1:0]  eligible, arb_grant, wb_vec, abort_vec;
  logic [SRC_W-1:0]  arb_idx, wb_low;
  logic              arb_any, all_ack, wb_multi;
  logic [1:0]        win_msg;
  logic [ADDR_W-1:0] win_addr;

  rr_arbiter #(.N_CPU(N_CPU)) u_rr_arbiter (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Request qualification and snoop response decode. The owner's own
  // ack/signal is masked off: it never snoops its own broadcast.
  always_comb begin
    eligible = '0;
    wb_vec   = '0;
    abort_vec = '0;
    win_msg  = '0;
    win_addr = '0;
    wb_low   = '0;
    for (int i = 0; i < N_CPU; i++) begin
      eligible[i]  = bus.i_Req[i] && (bus.i_Req_Msg[2*i +: 2] != MSG_NONE);
      wb_vec[i]    = bus.i_Snoop_Signal[2*i]     && !owner_oh_q[i];
      abort_vec[i] = bus.i_Snoop_Signal[2*i + 1] && !owner_oh_q[i];
      if (arb_grant[i]) begin
        win_msg  = bus.i_Req_Msg[2*i +: 2];
        win_addr = bus.i_Req_Addr[ADDR_W*i +: ADDR_W];
      end
    end
    // Descending scan so the lowest writeback index is the one left standing.
    for (int i = N_CPU - 1; i >= 0; i--) begin
      if (wb_vec[i]) wb_low = SRC_W'(i);
    end
    all_ack  = &(bus.i_Snoop_Ack | owner_oh_q);
    wb_multi = ($countones(wb_vec) > 1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (arb_any) state_d = ST_GRANT;
      ST_GRANT:     state_d = ST_BROADCAST;
      ST_BROADCAST: begin
        if (all_ack) begin
          if (|wb_vec)
            state_d = ST_WRITEBACK;
          else if (msg_q == MSG_READ_MISS || msg_q == MSG_WRITE_MISS)
            state_d = ST_FETCH;
          else
            state_d = ST_DONE;
        end
      end
      ST_WRITEBACK: if (bus.i_Mem_Done) state_d = abort_q ? ST_BROADCAST : ST_FETCH;
      ST_FETCH:     if (bus.i_Mem_Done) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      owner_oh_q <= '0;
      ptr_q      <= '0;
      wb_src_q   <= '0;
      msg_q      <= '0;
      addr_q     <= '0;
      abort_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Transaction fields are captured once; later requester changes are ignored.
      if (state_q == ST_IDLE && arb_any) begin
        owner_q    <= arb_idx;
        owner_oh_q <= arb_grant;
        msg_q      <= win_msg;
        addr_q     <= win_addr;
      end
      if (state_q == ST_BROADCAST && all_ack) begin
        wb_src_q <= wb_low;
        abort_q  <= |abort_vec;
        if (wb_multi) error_q <= 1'b1;
      end
      if (state_q == ST_DONE) begin
        ptr_q      <= (owner_q == LAST) ? '0 : owner_q + 1'b1;
        owner_oh_q <= '0;
      end
    end
  end

  // All outputs decode from registered state, so reset clears them at once.
  always_comb begin
    bus.o_Grant     = '0;
    bus.o_Bus_Valid = 1'b0;
    bus.o_Bus_Msg   = msg_q;
    bus.o_Bus_Addr  = addr_q;
    bus.o_Bus_Src   = owner_q;
    bus.o_Mem_Req   = 1'b0;
    bus.o_Mem_Wb    = 1'b0;
    bus.o_Mem_Src   = '0;
    bus.o_Done      = '0;
    bus.o_Error     = error_q;
    case (state_q)
      ST_GRANT:     bus.o_Grant = owner_oh_q;
      ST_BROADCAST: begin
        bus.o_Grant     = owner_oh_q;
        bus.o_Bus_Valid = 1'b1;
      end
      ST_WRITEBACK: begin
        bus.o_Grant   = owner_oh_q;
        bus.o_Mem_Req = 1'b1;
        bus.o_Mem_Wb  = 1'b1;
        bus.o_Mem_Src = wb_src_q;
      end
      ST_FETCH: begin
        bus.o_Grant   = owner_oh_q;
        bus.o_Mem_Req = 1'b1;
        bus.o_Mem_Src = owner_q;
      end
      ST_DONE:      bus.o_Done = owner_oh_q;
      default: ;
    endcase
  end

endmodule
